// File: rtl/keypad_auth.sv
// Keypad authentication controller for the smart lock.
// Collects digits, checks them against a stored passcode and issues single-cycle
// unlock/lock command pulses. Repeated failures cause a timed lockout, and an
// unlocked door relocks automatically after a fixed number of cycles.
module keypad_auth #(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] CODE           = 16'h1234,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  RELOCK_CYCLES  = 500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic       o_unlock,
  output logic       o_lock,
  output logic       o_lockout,
  output logic [2:0] o_fail_count,
  output logic [3:0] o_digit_count
);

  // One timer serves both the relock and the lockout interval; it is sized for the longer one.
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  localparam int RW = $clog2(RELOCK_CYCLES) + 1;
  localparam int CW = (LW > RW) ? LW : RW;
  localparam int EW = 4 * DIGITS;

  localparam logic [CW-1:0] LOCK_LOAD   = CW'(LOCKOUT_CYCLES);
  localparam logic [CW-1:0] RELOCK_LOAD = CW'(RELOCK_CYCLES);
  localparam logic [CW-1:0] TIMER_LAST  = CW'(1);
  localparam logic [3:0]    DIG_MAX     = 4'(DIGITS);
  localparam logic [2:0]    FAIL_MAX    = 3'(MAX_FAILS);

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;
  localparam logic [3:0] K_LOCK  = 4'hC;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UNLOCKED, S_LOCKOUT} state_t;

  state_t          r_state;
  logic [EW-1:0]   r_entry;
  logic            r_ovf;
  logic [CW-1:0]   r_timer;
  logic            r_unlock;
  logic            r_lock;
  logic            r_lockout;
  logic [2:0]      r_fail;
  logic [3:0]      r_digits;

  logic            w_is_digit;
  logic            w_is_clear;
  logic            w_is_enter;
  logic            w_is_lock;
  logic            w_match;
  logic            w_timer_done;
  logic [2:0]      w_fail_next;
  logic [EW-1:0]   w_shifted;

  assign w_is_digit   = i_key_valid && (i_key_code <= 4'd9);
  assign w_is_clear   = i_key_valid && (i_key_code == K_CLEAR);
  assign w_is_enter   = i_key_valid && (i_key_code == K_ENTER);
  assign w_is_lock    = i_key_valid && (i_key_code == K_LOCK);
  // New digits enter at the low nibble, so the first digit ends up most significant.
  assign w_shifted    = EW'({r_entry, i_key_code});
  assign w_match      = (r_digits == DIG_MAX) && !r_ovf && (r_entry == CODE);
  assign w_fail_next  = r_fail + 3'd1;
  // The timer is loaded with N and the state is left on the edge where it would reach 0,
  // giving exactly N cycles in UNLOCKED/LOCKOUT.
  assign w_timer_done = (r_timer <= TIMER_LAST);

  assign o_unlock      = r_unlock;
  assign o_lock        = r_lock;
  assign o_lockout     = r_lockout;
  assign o_fail_count  = r_fail;
  assign o_digit_count = r_digits;

  // Control FSM with registered command pulses, entry capture and interval timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_INIT;
      r_entry   <= '0;
      r_ovf     <= 1'b0;
      r_timer   <= '0;
      r_unlock  <= 1'b0;
      r_lock    <= 1'b0;
      r_lockout <= 1'b0;
      r_fail    <= '0;
      r_digits  <= '0;
    end else begin
      r_unlock <= 1'b0;
      r_lock   <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_lock  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_is_digit) begin
            if (r_digits < DIG_MAX) begin
              r_entry  <= w_shifted;
              r_digits <= r_digits + 4'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (w_is_clear) begin
            r_entry  <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
          end else if (w_is_enter) begin
            r_entry  <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
            if (w_match) begin
              r_unlock <= 1'b1;
              r_fail   <= '0;
              r_timer  <= RELOCK_LOAD;
              r_state  <= S_UNLOCKED;
            end else if (w_fail_next == FAIL_MAX) begin
              r_fail    <= '0;
              r_timer   <= LOCK_LOAD;
              r_lockout <= 1'b1;
              r_state   <= S_LOCKOUT;
            end else begin
              r_fail <= w_fail_next;
            end
          end else if (w_is_lock) begin
            r_lock   <= 1'b1;
            r_entry  <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
          end
        end
        S_UNLOCKED: begin
          // Expiry and lock key share one branch, so a coincidence yields a single pulse.
          if (w_timer_done || w_is_lock) begin
            r_lock  <= 1'b1;
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_LOCKOUT: begin
          // The door is already locked here, so leaving lockout emits no pulse.
          if (w_timer_done) begin
            r_lockout <= 1'b0;
            r_timer   <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/keypad_auth.md
# keypad_auth

Keypad authentication controller for the smart lock: it collects key presses and compares the entered digit sequence against a stored passcode. It issues single-cycle `unlock` and `lock` command pulses that drive the door-lock stage directly downstream. It also enforces a lockout after repeated failed attempts and auto-relocks after a timeout.

## Interface
- `DIGITS`, 4: passcode length in digits (1–8).
- `CODE`, 16'h1234: stored passcode, one BCD nibble per digit, first-entered digit in the most significant nibble; width 4*DIGITS.
- `MAX_FAILS`, 3: consecutive failed attempts (1–7) that trigger lockout.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clock cycles (≥1).
- `RELOCK_CYCLES`, 500: cycles spent unlocked before automatic relock (≥1).

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe: `key_code` is valid this cycle.
- `key_code`  in  4  0–9 digit; 4'hA clear (*); 4'hB enter (#); 4'hC lock button; 4'hD–4'hF ignored.
- `unlock`  out  1  one-cycle pulse that commands the door to unlock.
- `lock`  out  1  one-cycle pulse that commands the door to lock.
- `lockout`  out  1  level, high while in LOCKOUT.
- `fail_count`  out  3  current consecutive failures.
- `digit_count`  out  4  digits entered in the current attempt, saturating at DIGITS.

## Operation
- States: INIT, IDLE, UNLOCKED, LOCKOUT. Reset enters INIT.
- INIT lasts exactly one cycle. It emits one `lock` pulse and then goes to IDLE, so the door is always locked after reset.
- IDLE, digit key:
  - If `digit_count` < DIGITS, shift the digit into the entry register from the low nibble and increment `digit_count`.
  - Otherwise set the internal overflow flag. `digit_count` stays at DIGITS.
- IDLE, clear key: zero the entry register, `digit_count` and overflow. `fail_count` is unchanged.
- IDLE, enter key:
  - Match means `digit_count`==DIGITS, overflow clear, and entry==CODE. On match: `unlock` pulse, `fail_count`←0, go to UNLOCKED, load the relock counter with RELOCK_CYCLES.
  - Any other enter, including with zero digits, is a failure and increments `fail_count`. If the new value equals MAX_FAILS, go to LOCKOUT, load the lockout counter with LOCKOUT_CYCLES, and set `fail_count`←0.
  - Every enter, pass or fail, clears the entry register, `digit_count` and overflow.
- IDLE, lock key: emit a `lock` pulse and clear the entry. This is harmless re-locking.
- UNLOCKED:
  - Digits, clear and enter are ignored.
  - The relock counter decrements every cycle. Expiry (counter reaches 0), or a lock key, produces exactly one `lock` pulse and a move to IDLE.
  - If expiry and a lock key coincide, only one pulse is emitted.
- LOCKOUT: all keys are ignored. The counter decrements every cycle; when it reaches 0 the block goes to IDLE. No lock pulse is emitted, because the door is already locked.
- Codes 4'hD–4'hF are ignored in every state.
- `unlock` and `lock` are never high in the same cycle.
- Counters are sized with $clog2 of their load value plus 1 and never wrap.

## Timing
- Reset values: `unlock`=0, `lock`=0, `lockout`=0, `fail_count`=0, `digit_count`=0, state=INIT.
- The `lock` pulse from INIT is high for the first cycle after the first rising edge following `rst_n` release.
- All outputs are registered. A key sampled at edge N produces its output effect during cycle N+1, i.e. latched at edge N+1 by the downstream stage.
- `lockout` rises in the cycle after the failing enter. It stays high for exactly LOCKOUT_CYCLES cycles.
- Auto-relock: the `lock` pulse appears exactly RELOCK_CYCLES cycles after the `unlock` pulse.
- Back-to-back `key_valid` on consecutive cycles is legal. Each key is processed independently.
- `rst_n` low at any time, including mid-entry, during UNLOCKED or during LOCKOUT:
  - All state, counters and outputs clear immediately.
  - An `unlock` pulse in flight is dropped.
  - The INIT `lock` pulse follows release.

## Test plan
- Reset release → `lock`=1 for exactly one cycle; all other outputs 0; `digit_count`=0.
- Keys 1,2,3,4,# → `unlock` pulse one cycle after #; `fail_count`=0; `lock` pulse exactly 500 cycles later; state IDLE.
- Keys 1,2,3,5,# three times → `fail_count` goes 1 then 2. The third # raises `lockout` for 1000 cycles; a correct 1,2,3,4,# during lockout produces no `unlock`; after lockout, 1,2,3,4,# unlocks.
- Keys 1,2,3,4,5,# (overflow) → fail, `fail_count`=1. Then 9,*,1,2,3,4,# → `unlock`, and `fail_count` returns to 0.
- Unlocked, lock key (4'hC) at cycle 200 → one `lock` pulse and no second pulse at cycle 500. A lock key exactly at the relock-expiry cycle → a single `lock` pulse.
- `rst_n` asserted mid-entry after 1,2 and again during LOCKOUT → outputs clear at once; after release, a `lock` pulse, then 3,4,# fails (the entry was not retained).
